// File: rtl/wb_serial_port.sv
// wb_serial_port: Wishbone-attached 8N1 serial port. It has a TX FIFO and an
// RX FIFO, sticky error flags and a programmable 16-bit bit-period divisor.
// TX FIFO entries stay in the FIFO while they are on the wire and are popped
// at the end of the stop bit. Occupancy therefore includes the byte in flight.
module wb_serial_port #(
    parameter int DEFAULT_DIV = 234,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    output logic       wb_ack_o,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Handshake: a request is accepted when cyc & stb are high and ack is low.
    // The ack follows on the next cycle, together with the read data. Each
    // accepted request applies its side effect exactly once.
    logic [3:0] adr;
    logic       access, wr_data, rd_data, wr_status;
    logic       unused_adr;
    assign adr        = wb_adr_i[3:0];
    assign unused_adr = ^wb_adr_i[7:4];
    assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_data    = access & wb_we_i & (adr == 4'h0);
    assign rd_data    = access & ~wb_we_i & (adr == 4'h0);
    assign wr_status  = access & wb_we_i & (adr == 4'h1);

    logic [15:0] div_reg, div_eff;
    assign div_eff = (div_reg < 16'd16) ? 16'd16 : div_reg;

    // FIFO storage and pointers. The extra pointer MSB distinguishes full from empty.
    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wr, tx_rd, rx_wr, rx_rd, tx_count;
    logic tx_empty, tx_full, rx_empty, rx_full;
    assign tx_count = tx_wr - tx_rd;
    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);

    logic tx_overflow, rx_overrun, frame_err;

    // Transmit state.
    state_t      tx_state;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_head;
    logic        tx_bit_end, tx_pop, tx_push, tx_drop, tx_more;
    assign tx_head    = tx_mem[tx_rd[AW-1:0]];
    assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
    assign tx_pop     = (tx_state == S_STOP) & tx_bit_end;
    assign tx_push    = wr_data & (~tx_full | tx_pop);
    assign tx_drop    = wr_data & ~tx_push;
    assign tx_more    = (tx_count > PTR_ONE) | tx_push;

    // Receive state.
    state_t      rx_state;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_bit_end, rx_half_end, rx_stop_done, rx_push, rx_pop;
    assign rx_bit_end   = (rx_cnt == rx_div - 16'd1);
    assign rx_half_end  = (rx_cnt == (rx_div >> 1) - 16'd1);
    assign rx_stop_done = (rx_state == S_STOP) & rx_bit_end;
    assign rx_pop       = rd_data & ~rx_empty;
    assign rx_push      = rx_stop_done & rx_s2 & (~rx_full | rx_pop);

    logic [7:0] status;
    assign status = {(tx_state != S_IDLE), frame_err, rx_overrun, tx_overflow,
                     rx_full, rx_empty, tx_empty, tx_full};

    // FIFO memory writes. The contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= wb_dat_i;
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_sh;
    end

    // Bus response, FIFO pointers, divisor and sticky flags. When a flag is set and cleared in the same cycle, the set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= 8'h00;
            tx_wr       <= '0;
            tx_rd       <= '0;
            rx_wr       <= '0;
            rx_rd       <= '0;
            div_reg     <= 16'(DEFAULT_DIV);
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
            wb_dat_o <= 8'h00;
            if (access & ~wb_we_i) begin
                case (adr)
                    4'h0:    wb_dat_o <= rx_empty ? 8'h00 : rx_mem[rx_rd[AW-1:0]];
                    4'h1:    wb_dat_o <= status;
                    4'h2:    wb_dat_o <= div_reg[7:0];
                    4'h3:    wb_dat_o <= div_reg[15:8];
                    default: wb_dat_o <= 8'h00;
                endcase
            end
            if (access & wb_we_i & (adr == 4'h2)) div_reg[7:0]  <= wb_dat_i;
            if (access & wb_we_i & (adr == 4'h3)) div_reg[15:8] <= wb_dat_i;
            if (tx_push) tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
            if (rx_push) rx_wr <= rx_wr + PTR_ONE;
            if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
            tx_overflow <= (tx_overflow & ~(wr_status & wb_dat_i[4])) | tx_drop;
            rx_overrun  <= (rx_overrun & ~(wr_status & wb_dat_i[5])) |
                           (rx_stop_done & rx_s2 & ~rx_push);
            frame_err   <= (frame_err & ~(wr_status & wb_dat_i[6])) |
                           (rx_stop_done & ~rx_s2);
        end
    end

    // TX framing FSM. Each bit period latches the divisor in effect at its start.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= 16'd16;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (!tx_empty) begin
                        tx_state <= S_START;
                        uart_tx  <= 1'b0;
                        tx_cnt   <= '0;
                        tx_div   <= div_eff;
                    end
                end
                S_START: begin
                    if (tx_bit_end) begin
                        tx_state <= S_DATA;
                        uart_tx  <= tx_head[0];
                        tx_bit   <= '0;
                        tx_cnt   <= '0;
                        tx_div   <= div_eff;
                    end else tx_cnt <= tx_cnt + 16'd1;
                end
                S_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            uart_tx <= tx_head[3'(tx_bit + 3'd1)];
                            tx_bit  <= tx_bit + 3'd1;
                        end
                        tx_cnt <= '0;
                        tx_div <= div_eff;
                    end else tx_cnt <= tx_cnt + 16'd1;
                end
                default: begin
                    if (tx_bit_end) begin
                        tx_state <= tx_more ? S_START : S_IDLE;
                        uart_tx  <= ~tx_more;
                        tx_cnt   <= '0;
                        tx_div   <= div_eff;
                    end else tx_cnt <= tx_cnt + 16'd1;
                end
            endcase
        end
    end

    // RX synchroniser, falling-edge detect and mid-bit sampling FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= 16'd16;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev & ~rx_s2) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                        rx_div   <= div_eff;
                    end
                end
                S_START: begin
                    if (rx_half_end) begin
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                        rx_bit   <= '0;
                        rx_cnt   <= '0;
                        rx_div   <= div_eff;
                    end else rx_cnt <= rx_cnt + 16'd1;
                end
                S_DATA: begin
                    if (rx_bit_end) begin
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        rx_cnt <= '0;
                        rx_div <= div_eff;
                    end else rx_cnt <= rx_cnt + 16'd1;
                end
                default: begin
                    if (rx_bit_end) begin
                        rx_state <= S_IDLE;
                        rx_cnt   <= '0;
                    end else rx_cnt <= rx_cnt + 16'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_serial_port.sv
// Bench for wb_serial_port. A bus driver, a serial line monitor and a model of
// both FIFOs at byte level. One process checks every acknowledged read.
module tb_wb_serial_port;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic       wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
    logic       uart_rx, uart_tx;
    logic       loop_en = 1'b0, drv_rx = 1'b1;

    assign uart_rx = loop_en ? uart_tx : drv_rx;

    wb_serial_port dut (
        .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o), .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;
    initial begin
        repeat (150000) @(negedge clk);
        $display("FAIL watchdog: simulation exceeded 150000 cycles");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model state.
    logic [7:0] exp_q[$];
    bit         acc_we_q[$];
    string      acc_name_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_model_q[$];
    int         mon_div   = 234;
    bit         mon_en    = 1'b1;
    int         mon_count = 0;

    function automatic int eff_div(input int d);
        return (d < 16) ? 16 : d;
    endfunction

    // Scoreboard: every acknowledged read is compared against the queued expectation.
    always @(negedge clk) begin
        if (wb_ack_o) begin
            if (exp_q.size() == 0) chk("spurious_ack", 1, 0);
            else begin
                logic [7:0] e;
                bit         w;
                string      nm;
                e  = exp_q.pop_front();
                w  = acc_we_q.pop_front();
                nm = acc_name_q.pop_front();
                if (!w) chk(nm, wb_dat_o, e);
            end
        end
    end

    // Serial monitor: decodes each frame on uart_tx at the mid-point of every bit.
    logic       mon_prev = 1'b1;
    logic       mon_start, mon_stop;
    logic [7:0] mon_byte;
    int         mon_d;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_prev && uart_tx === 1'b0) begin
                mon_d = eff_div(mon_div);
                repeat (mon_d / 2) @(negedge clk);
                mon_start = uart_tx;
                for (int k = 0; k < 9; k++) begin
                    repeat (mon_d - mon_d / 2) @(negedge clk);
                    mon_d = eff_div(mon_div);
                    repeat (mon_d / 2) @(negedge clk);
                    if (k < 8) mon_byte[k] = uart_tx;
                    else       mon_stop    = uart_tx;
                end
                if (mon_en) begin
                    mon_count++;
                    chk("tx_start_bit", mon_start, 0);
                    chk("tx_stop_bit", mon_stop, 1);
                    if (tx_exp_q.size() == 0) chk("tx_unexpected_frame", 1, 0);
                    else chk("tx_frame_byte", mon_byte, tx_exp_q.pop_front());
                end
                mon_prev = uart_tx;
            end else mon_prev = uart_tx;
        end
    end

    // Driver tasks.
    task automatic wb_access(input bit we, input logic [7:0] adr, input logic [7:0] dat,
                             input logic [7:0] exp, input string name);
        int waited;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        acc_we_q.push_back(we);
        exp_q.push_back(exp);
        acc_name_q.push_back(name);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wb_ack_o && waited < 8);
        chk({name, "_ack_latency"}, waited, 1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (we && adr == 8'h02) mon_div = (mon_div & 'hFF00) | int'(dat);
        if (we && adr == 8'h03) mon_div = (mon_div & 'h00FF) | (int'(dat) << 8);
    endtask

    task automatic wr(input logic [7:0] adr, input logic [7:0] dat, input string name);
        wb_access(1'b1, adr, dat, 8'h00, name);
    endtask

    task automatic rd(input logic [7:0] adr, input logic [7:0] exp, input string name);
        wb_access(1'b0, adr, 8'h00, exp, name);
    endtask

    task automatic rd_data(input string name);
        logic [7:0] e;
        e = (rx_model_q.size() != 0) ? rx_model_q.pop_front() : 8'h00;
        rd(8'h00, e, name);
    endtask

    task automatic tx_byte(input logic [7:0] b);
        if (mon_en && tx_exp_q.size() < 16) begin
            tx_exp_q.push_back(b);
            if (loop_en) rx_model_q.push_back(b);
        end
        wr(8'h00, b, "tx_data_wr");
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            drv_rx = f[i];
            repeat (16) @(negedge clk);
        end
        drv_rx = 1'b1;
        repeat (32) @(negedge clk);
        if (stop && rx_model_q.size() < 16) rx_model_q.push_back(b);
    endtask

    task automatic wait_tx_drain(input int limit);
        int n;
        n = 0;
        while (tx_exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("tx_drain_timeout", (tx_exp_q.size() != 0), 0);
    endtask

    // Directed sequence.
    initial begin
        logic [9:0] fr;
        logic [3:0] pat;
        int         base;
        bit         saw_low;

        repeat (3) @(negedge clk);
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_dat", wb_dat_o, 8'h00);
        chk("rst_tx", uart_tx, 1);
        rst = 1'b0;

        rd(8'h01, 8'h06, "status_reset");
        rd(8'h02, 8'hEA, "div_lo_reset");
        rd(8'h03, 8'h00, "div_hi_reset");
        rd_data("data_empty_reset");
        rd(8'h07, 8'h00, "unmapped_read");
        wr(8'h07, 8'hFF, "unmapped_wr");
        rd(8'h01, 8'h06, "status_after_unmapped_wr");

        // Held strobe: acks on alternate cycles, each with valid data.
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h02;
        for (int i = 0; i < 2; i++) begin
            acc_we_q.push_back(1'b0);
            exp_q.push_back(8'hEA);
            acc_name_q.push_back("held_read");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = wb_ack_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        chk("held_ack_pattern", pat, 4'b0101);

        // TX waveform of 0xA5 at divisor 16, checked every cycle.
        wr(8'h02, 8'h10, "div_lo_wr");
        wr(8'h03, 8'h00, "div_hi_wr");
        rd(8'h02, 8'h10, "div_lo_readback");
        fr = {1'b1, 8'hA5, 1'b0};
        tx_byte(8'hA5);
        chk("tx_idle_before_start", uart_tx, 1);
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            chk("tx_a5_wave", uart_tx, fr[i / 16]);
        end
        repeat (4) @(negedge clk);
        chk("tx_a5_after", uart_tx, 1);
        rd(8'h01, 8'h06, "status_after_a5");

        // Loopback with a divisor below the minimum, which is clamped to 16.
        wr(8'h02, 8'h05, "div_lo_small");
        rd(8'h02, 8'h05, "div_lo_raw");
        loop_en = 1'b1;
        tx_byte(8'h3C);
        tx_byte(8'hC3);
        wait_tx_drain(2000);
        repeat (40) @(negedge clk);
        rd_data("loop_data0");
        rd_data("loop_data1");
        rd(8'h01, 8'h06, "status_loop_idle");
        loop_en = 1'b0;

        // RX faults: frame error, then overrun.
        wr(8'h02, 8'h10, "div_lo_wr");
        send_frame(8'h55, 1'b0);
        rd(8'h01, 8'h46, "status_frame_err");
        rd_data("data_after_frame_err");
        wr(8'h01, 8'h40, "clear_frame_err");
        rd(8'h01, 8'h06, "status_frame_err_cleared");
        for (int i = 0; i < 17; i++) send_frame(8'(i * 37 + 11), 1'b1);
        rd(8'h01, 8'h2A, "status_rx_overrun");
        for (int i = 0; i < 16; i++) rd_data("rx_fifo_data");
        rd_data("rx_data_empty");
        rd(8'h01, 8'h26, "status_rx_drained");
        wr(8'h01, 8'h5F, "clear_other_bits");
        rd(8'h01, 8'h26, "status_overrun_kept");
        wr(8'h01, 8'h20, "clear_overrun");
        rd(8'h01, 8'h06, "status_overrun_cleared");

        // False start: a low pulse of a quarter bit.
        @(negedge clk);
        drv_rx = 1'b0;
        repeat (4) @(negedge clk);
        drv_rx = 1'b1;
        repeat (60) @(negedge clk);
        rd(8'h01, 8'h06, "status_false_start");
        rd_data("data_false_start");

        // TX overflow with the slowest divisor, then speed up to drain.
        wr(8'h02, 8'hFF, "div_lo_max");
        wr(8'h03, 8'hFF, "div_hi_max");
        base = mon_count;
        for (int i = 0; i < 17; i++) tx_byte(8'(8'h80 + i));
        rd(8'h01, 8'h95, "status_tx_overflow");
        wr(8'h01, 8'h10, "clear_tx_overflow");
        rd(8'h01, 8'h85, "status_tx_overflow_cleared");
        wr(8'h02, 8'h10, "div_lo_fast");
        wr(8'h03, 8'h00, "div_hi_fast");
        wait_tx_drain(80000);
        chk("tx_sent_count", mon_count - base, 16);
        repeat (40) @(negedge clk);
        rd(8'h01, 8'h06, "status_after_drain");

        // Reset during the 4th data bit of a frame.
        mon_en = 1'b0;
        tx_byte(8'hA5);
        repeat (70) @(negedge clk);
        chk("tx_bit3_before_rst", uart_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", uart_tx, 1);
        chk("rst_mid_ack", wb_ack_o, 0);
        chk("rst_mid_dat", wb_dat_o, 8'h00);
        rst = 1'b0;
        mon_div = 234;
        saw_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) saw_low = 1'b1;
        end
        chk("tx_stays_idle_after_rst", saw_low, 0);
        rd(8'h01, 8'h06, "status_after_rst");
        rd(8'h02, 8'hEA, "div_lo_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_serial_port.md
WB_SERIAL_PORT -- requirements
Module: wb_serial_port

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 234, meaning the reset-time bit period in clk cycles (27 MHz / 234 is approx. 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the entries per TX and RX FIFO (power of two, at least 4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port wb_adr_i, input, 8 bits: Wishbone address; only [3:0] are decoded.
REQ-006 SHALL have port wb_dat_i, input, 8 bits: Wishbone write data.
REQ-007 SHALL have port wb_dat_o, output, 8 bits: Wishbone read data.
REQ-008 SHALL have ports wb_cyc_i, wb_stb_i and wb_we_i, each input, 1 bit: Wishbone cycle, strobe and write-enable.
REQ-009 SHALL have port wb_ack_o, output, 1 bit: Wishbone acknowledge.
REQ-010 SHALL have port uart_rx, input, 1 bit: asynchronous serial input, idle high.
REQ-011 SHALL have port uart_tx, output, 1 bit: serial output, idle high.

Function
REQ-012 SHALL decode the following registers on wb_adr_i[3:0]:
- 0x0: DATA. Write pushes the TX FIFO; read pops the RX FIFO.
- 0x1: STATUS (read-only bits and write-1-to-clear bits).
- 0x2: DIV_LO.
- 0x3: DIV_HI.
- Any other address reads 0x00 and ignores writes.
REQ-013 SHALL define STATUS as:
- bit0 tx_full
- bit1 tx_empty
- bit2 rx_empty
- bit3 rx_full
- bit4 tx_overflow (sticky)
- bit5 rx_overrun (sticky)
- bit6 frame_err (sticky)
- bit7 tx_busy (shifter active)
REQ-014 SHALL assert wb_ack_o for exactly one cycle, on the cycle after it samples wb_cyc_i & wb_stb_i high with wb_ack_o low; a held strobe therefore yields ack on every other cycle.
REQ-015 SHALL present read data on wb_dat_o in the same cycle as wb_ack_o, and SHALL perform each side effect (push, pop or clear) exactly once per acknowledged access.
REQ-016 SHALL return 0x00 when DATA is read while the RX FIFO is empty, with no pop and no flag change.
REQ-017 SHALL drop a DATA write made while the TX FIFO is full and set tx_overflow.
REQ-018 SHALL clear a sticky flag when STATUS is written with a 1 in that bit position; all other bits are unaffected.
REQ-019 SHALL hold a 16-bit divisor written through DIV_LO and DIV_HI; any value below 16 SHALL be treated as 16.
REQ-020 SHALL run the TX state machine IDLE -> START -> DATA(8 bits) -> STOP -> IDLE, each bit lasting exactly divisor cycles:
- 8N1 framing, LSB first.
- Leaves IDLE on the cycle after the TX FIFO becomes non-empty.
- Goes back-to-back with no idle gap while the FIFO is non-empty.
REQ-021 SHALL synchronise uart_rx through two flip-flops before any use.
REQ-022 SHALL run the RX state machine IDLE -> START -> DATA -> STOP -> IDLE:
- A falling edge in IDLE enters START.
- Re-checks the line at divisor/2. If the line is high, it is a false start: return to IDLE.
- Samples the data bits and then the stop bit at divisor intervals after that point.
REQ-023 SHALL handle the received stop bit as follows:
- Stop bit low: discard the byte and set frame_err.
- Stop bit high and RX FIFO full: discard the byte and set rx_overrun.
- Otherwise: push the byte.
REQ-024 SHALL honour both operations when a push and a pop of the same FIFO occur in one cycle, including in the full state; the occupancy is unchanged.
REQ-025 SHALL apply a divisor change at the start of the next bit period; a frame already in progress is not restarted.

Reset
REQ-026 SHALL, on rst, drive wb_ack_o=0, wb_dat_o=0x00 and uart_tx=1 from the next clock edge.
REQ-027 SHALL, on rst, empty both FIFOs, clear all sticky flags, load divisor=DEFAULT_DIV, and place both state machines in IDLE.
REQ-028 SHALL, when rst occurs mid-frame, abort the frame: uart_tx goes high on the next cycle and the partially shifted bytes are lost.

Verification
REQ-029 SHALL pass this TX case: divisor=16, write 0xA5 to DATA -> uart_tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then high; tx_busy clears after the stop bit.
REQ-030 SHALL pass this loopback case: uart_tx tied to uart_rx, write 0x3C and 0xC3 -> later, DATA reads return 0x3C then 0xC3, and STATUS reads 0x06 when idle.
REQ-031 SHALL pass this TX overflow case: 17 DATA writes with divisor=0xFFFF -> tx_full=1 and tx_overflow=1; writing 0x10 to STATUS clears bit4; 16 bytes are transmitted.
REQ-032 SHALL pass this RX fault case: inject a frame with its stop bit low -> frame_err=1 and rx_empty stays 1; inject 17 valid frames without reading -> rx_overrun=1 and the first 16 bytes are retained.
REQ-033 SHALL pass this false-start case: a low pulse of divisor/4 cycles on uart_rx -> no byte is pushed and no flag is set.
REQ-034 SHALL pass this reset case: assert rst during the 4th data bit of a TX frame -> uart_tx=1, STATUS=0x06, and a DIV_LO read returns 0xEA (DEFAULT_DIV low byte).
